uart_tx_ctrl: RTL

//   Transmit sequencer for the UART TX path. Accepts a byte over a valid/ready handshake,

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART TX/RX controllers: FSM state
//               encodings, serial-line idle level and a counter-width helper.
// Contents    : uart_state_t    - IDLE/START/DATA/PARITY/STOP encodings
//               UART_IDLE_LEVEL - level of the serial line between frames
//               uart_cnt_width  - $clog2-based width, never less than 1
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Width of a counter that must hold 0..n-1. A one-value counter still
  // needs a one-bit register so that port and compare widths stay legal.
  function automatic int uart_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high
//               and flags the last cycle of every bit period. Shared by the
//               UART TX and RX controllers.
// Ports       : clk     in  system clock
//               reset   in  synchronous active-high reset
//               run     in  count enable (controller is inside a frame)
//               clear   in  restart the bit period (frame accepted)
//               bit_end out high on the last clock of the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // Gated with run so a single-cycle bit period does not flag in IDLE.
  assign bit_end = run && (baud_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      baud_cnt <= '0;
    end else if (run) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit sequencer. Accepts a byte on a valid/ready
//               handshake, drives the external tx_piso shift register and
//               frames the serial line: start bit, DATA_BITS data bits LSB
//               first, optional even-parity bit, stop bit.
// Config      : define UART_TX_PARITY_EN to insert the even-parity bit.
// Ports       : clk        in  system clock
//               reset      in  synchronous active-high reset
//               tx_valid   in  host presents a byte
//               tx_data    in  byte to send, sampled on accept
//               tx_ready   out high only while idle
//               piso_load  out load strobe to tx_piso (equals accept)
//               piso_data  out parallel data to tx_piso (tx_data)
//               piso_shift out one-cycle pulse at the end of each data bit
//               piso_out   in  current data bit from tx_piso
//               tx         out serial line, idles high
//               busy       out high whenever a frame is in progress
//               tx_done    out one-cycle pulse in the first idle cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 piso_load,
  output logic [DATA_BITS-1:0] piso_data,
  output logic                 piso_shift,
  input  logic                 piso_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BIT_CNT_W = uart_cnt_width(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_reg;
`endif

  // Reset masks the handshake so no load strobe escapes during reset.
  assign accept     = tx_valid && tx_ready && !reset;
  assign piso_load  = accept;
  assign piso_data  = tx_data;
  // The shift at the end of the last data bit is harmless: tx_piso is
  // reloaded before its contents are used again.
  assign piso_shift = (state == ST_DATA) && bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .run    (busy),
    .clear  (accept),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_START;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_reg  <= ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (bit_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_end) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Decoded only from registers (state, par_reg, tx_piso output) so the
  // line cannot glitch on handshake activity.
  always_comb begin
    tx = UART_IDLE_LEVEL;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = piso_out;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = par_reg;
`endif
      default:   tx = UART_IDLE_LEVEL;
    endcase
  end

endmodule
`default_nettype wire
